// File: rtl/instr_encoder_if.sv
// Bundles the encode-request side and the instruction-memory write side of
// the encoder. The encoder sits on the slave modport; whatever feeds it
// requests and drains its writes sits on the master modport.
interface instr_encoder_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Encode request
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op_sel;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [15:0]   imm;
    logic [25:0]   target;

    // Write-address control
    logic          addr_load;
    logic [AW-1:0] addr_val;

    // Instruction-memory write port
    logic          wr_en;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;

    // Status
    logic          illegal;
    logic [CW-1:0] count;

    modport slave (
        input  in_valid, op_sel, rs, rt, rd, imm, target,
        input  addr_load, addr_val, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data, illegal, count
    );

    modport master (
        output in_valid, op_sel, rs, rt, rd, imm, target,
        output addr_load, addr_val, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data, illegal, count
    );
endinterface

// File: rtl/instr_encoder.sv
// MIPS-style instruction encoder. Each accepted request is turned into a
// 32-bit instruction word and queued in a small FIFO; the FIFO head is
// written to instruction memory at an auto-incrementing word address.
// Illegal mnemonics are dropped and flagged with a one-cycle pulse.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_encoder_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

    // Mnemonic codes on op_sel
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_J    = 4'd9;

    // Primary opcode field values
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_J     = 6'b000010;

    // R-type function field values
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          illegal_q, illegal_d;

    logic [31:0]   enc_word;
    logic          enc_legal;
    logic          in_ready;
    logic          wr_en;
    logic          accept;
    logic          push;
    logic          pop;

    // Translate the mnemonic and register/immediate fields into an instruction word
    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (bus.op_sel)
            OP_ADD:  enc_word = {OPC_RTYPE, bus.rs, bus.rt, bus.rd, 5'b00000, FN_ADD};
            OP_SUB:  enc_word = {OPC_RTYPE, bus.rs, bus.rt, bus.rd, 5'b00000, FN_SUB};
            OP_AND:  enc_word = {OPC_RTYPE, bus.rs, bus.rt, bus.rd, 5'b00000, FN_AND};
            OP_OR:   enc_word = {OPC_RTYPE, bus.rs, bus.rt, bus.rd, 5'b00000, FN_OR};
            OP_SLT:  enc_word = {OPC_RTYPE, bus.rs, bus.rt, bus.rd, 5'b00000, FN_SLT};
            OP_LW:   enc_word = {OPC_LW,   bus.rs, bus.rt, bus.imm};
            OP_SW:   enc_word = {OPC_SW,   bus.rs, bus.rt, bus.imm};
            OP_BEQ:  enc_word = {OPC_BEQ,  bus.rs, bus.rt, bus.imm};
            OP_ADDI: enc_word = {OPC_ADDI, bus.rs, bus.rt, bus.imm};
            OP_J:    enc_word = {OPC_J, bus.target};
            default: enc_legal = 1'b0;
        endcase
    end

    // Handshake decode: ready only reflects stored occupancy, never a same-edge pop
    always_comb begin
        in_ready = (count_q < FULL_LVL);
        wr_en    = (count_q != '0);
        accept   = bus.in_valid && in_ready;
        push     = accept && enc_legal;
        pop      = wr_en && bus.wr_ready;
    end

    // Next-state for FIFO pointers, occupancy, write address and illegal flag
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        addr_d    = addr_q;
        illegal_d = accept && !enc_legal;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A load overrides the post-write increment; the write in flight
        // still goes out at the old address because wr_addr is registered.
        if (bus.addr_load) begin
            addr_d = bus.addr_val;
        end else if (pop) begin
            addr_d = addr_q + AW'(1);
        end
    end

    // Control state registers; reset empties the queue and rewinds the address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            illegal_q <= illegal_d;
        end
    end

    // FIFO storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

    // Drive the interface outputs; data is forced to zero while empty so a
    // reset or drained queue never exposes stale storage
    always_comb begin
        bus.in_ready = in_ready;
        bus.wr_en    = wr_en;
        bus.wr_addr  = addr_q;
        bus.wr_data  = wr_en ? mem_q[rd_ptr_q] : 32'h0;
        bus.illegal  = illegal_q;
        bus.count    = count_q;
    end
endmodule
